// File: rtl/data_memo_if.sv
// Memory-stage load/store bus between the pipeline and the data memory.
interface data_memo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) ();
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output mem_read,
        output mem_write,
        output addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/data_memo.sv
// Word-addressed data memory: synchronous write, registered read-before-write load,
// contents zero at power-up and untouched by reset.
module data_memo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH_BITS = 11
) (
    input  logic             clk,
    input  logic             rst,
    data_memo_if.slave       bus
);
    localparam int DEPTH = 2 ** DEPTH_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] read_data_d;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [DEPTH_BITS-1:0] word_idx;
    logic                  wr_en;

    // Upper address bits alias onto the same words; they are deliberately dropped.
    wire unused_addr_bits = &{1'b0, bus.addr[ADDR_WIDTH-1:DEPTH_BITS]};

    assign word_idx = bus.addr[DEPTH_BITS-1:0];

    always_comb begin
        read_data_d = read_data_q;
        wr_en       = 1'b0;
        if (!rst) begin
            if (bus.mem_read) begin
                read_data_d = mem_q[word_idx];
            end
            if (bus.mem_write) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_idx] <= bus.write_data;
        end
    end

    // The load samples the pre-write word, so a same-edge store returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign bus.read_data = read_data_q;
endmodule

// File: tb/tb_data_memo.sv
// Directed bench for data_memo: table of load/store vectors plus hand-written
// reset, hold and read-before-write sequences.
module tb_data_memo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    data_memo_if bus ();

    data_memo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    // Drive one cycle of inputs, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [15:0] a, input logic [15:0] wd);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.addr       = a;
        bus.write_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expected);
        checks++;
        if (bus.read_data !== expected) begin
            errors++;
            $display("[TB] FAIL %s read_data=%h expected=%h", name, bus.read_data, expected);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'h0001, 16'hA05F, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0001, 16'h0300, 16'hA05F};
        vecs[2]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'hA05F};
        vecs[3]  = '{1'b1, 1'b0, 16'h0002, 16'h03F0, 16'h0000};
        vecs[4]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 16'h0002, 16'h030F, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 16'h0002, 16'h0303, 16'h030F};
        vecs[7]  = '{1'b1, 1'b0, 16'h5F01, 16'h0000, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 16'h0701, 16'h1234, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, 16'hFF01, 16'h0000, 16'h1234};
        vecs[10] = '{1'b1, 1'b0, 16'h0701, 16'h0000, 16'h1234};
        vecs[11] = '{1'b1, 1'b1, 16'h0002, 16'hBEEF, 16'h030F};
        vecs[12] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'hBEEF};
        vecs[13] = '{1'b0, 1'b0, 16'h0002, 16'h1111, 16'hBEEF};

        $display("[TB] start");
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.addr       = 16'h0003;
        bus.write_data = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_rdata);
        end

        // Write asserted during the power-up reset must not have landed.
        applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0000);
        checkOutput("reset_write_blocked_init", 16'h0000);

        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000);
        checkOutput("pre_reset_value", 16'hBEEF);

        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h0002, 16'h5555);
        checkOutput("reset_clears_rdata", 16'h0000);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 16'h0002, 16'h0000);
        checkOutput("hold_after_reset", 16'h0000);

        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000);
        checkOutput("contents_preserved", 16'hBEEF);

        applyStimulus(1'bx, 1'bx, 16'h0002, 16'h7777);
        checkOutput("x_ctrl_hold", 16'hBEEF);
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000);
        checkOutput("x_ctrl_no_write", 16'hBEEF);

        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000);
        checkOutput("word1_intact", 16'hA05F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
